svc_rv_imem_resp: RTL and testbench

Instruction-memory responder: the memory side of the core's imem_ren/imem_raddr/imem_rdata fetch interface. It serves fetches from an internal word array with selectable SRAM-style or BRAM-style latency, so that the IF stage in either MEM_TYPE mode can be driven by it. A sequential program-load port fills the array over a valid/ready stream before or between runs. It is used as the imem in cores, testbenches and FPGA tops.

---
 rtl/svc_rv_imem_resp.sv | 98 +++++++++
 tb/tb_svc_rv_imem_resp.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/svc_rv_imem_resp.sv
// Instruction-memory responder for the IF stage: word array with SRAM- or BRAM-style read
// latency, filled through a sequential valid/ready program-load stream.
module svc_rv_imem_resp #(
  parameter int          AW        = 10,
  parameter int          LATENCY   = 1,
  parameter logic [31:0] BASE      = 32'h0000_0000,
  parameter logic [31:0] OOR_INSTR = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          imem_ren,
  input  logic [31:0]   imem_raddr,
  output logic [31:0]   imem_rdata,
  input  logic          load_start,
  input  logic          load_valid,
  input  logic [31:0]   load_data,
  input  logic          load_last,
  output logic          load_ready,
  output logic          load_busy,
  output logic          load_done,
  output logic [AW:0]   load_count,
  output logic          err_overflow,
  output logic          err_misaligned
);

  typedef enum logic {IDLE, LOAD} state_t;

  localparam logic [32:0] BYTE_LIMIT = 33'd4 << AW;

  state_t        state;
  logic [31:0]   mem [0:(1<<AW)-1];

  logic [31:0]   off;
  logic          in_range;
  logic [AW-1:0] idx;
  logic [31:0]   fetch_word;
  logic          hs;
  logic          wr_en;

  // Decode: offset from BASE wraps at 32 bits, so addresses below BASE land out of range.
  assign off        = imem_raddr - BASE;
  assign in_range   = ({1'b0, off} < BYTE_LIMIT);
  assign idx        = off[AW+1:2];
  assign fetch_word = (in_range && state == IDLE) ? mem[idx] : OOR_INSTR;

  // load_start has priority over a simultaneous handshake, which is dropped.
  assign hs         = (state == LOAD) && load_valid && !load_start;
  assign wr_en      = hs && !load_count[AW];

  assign load_ready = (state == LOAD);
  assign load_busy  = (state == LOAD);

  always_ff @(posedge clk) begin
    if (wr_en) mem[load_count[AW-1:0]] <= load_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      load_count     <= '0;
      load_done      <= 1'b0;
      err_overflow   <= 1'b0;
      err_misaligned <= 1'b0;
    end else begin
      if (imem_ren && imem_raddr[1:0] != 2'b00) err_misaligned <= 1'b1;
      if (load_start) begin
        state          <= LOAD;
        load_count     <= '0;
        load_done      <= 1'b0;
        err_overflow   <= 1'b0;
        err_misaligned <= 1'b0;
      end else if (hs) begin
        // A full array still accepts the word but discards it; the count saturates.
        if (load_count[AW]) err_overflow <= 1'b1;
        else                load_count   <= load_count + 1'b1;
        if (load_last) begin
          state     <= IDLE;
          load_done <= 1'b1;
        end
      end
    end
  end

  generate
    if (LATENCY == 0) begin : g_comb
      assign imem_rdata = fetch_word;
    end else begin : g_reg
      logic [31:0] rdata_p1;
      // Stage p1: holds across ren=0 so a stalled IF stage keeps its instruction.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        rdata_p1 <= OOR_INSTR;
        else if (imem_ren) rdata_p1 <= fetch_word;
      end
      assign imem_rdata = rdata_p1;
    end
  endgenerate

endmodule

// File: tb/tb_svc_rv_imem_resp.sv
// Scoreboard bench for svc_rv_imem_resp: four instances (LATENCY 0/1, small AW, offset BASE)
// share one load stream; fetch responses are queued at issue and checked by a monitor.
module tb_svc_rv_imem_resp;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] P0 = 32'h0050_0093, P1 = 32'h0010_0113;
  localparam logic [31:0] P2 = 32'h0020_81B3, P3 = 32'h0000_006F;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic load_start = 1'b0, load_valid = 1'b0, load_last = 1'b0;
  logic [31:0] load_data = '0;
  logic        ren [4];
  logic [31:0] raddr [4];
  logic [31:0] rdata [4];
  logic        rdy [4], busy [4], done [4], eov [4], emis [4];
  logic [10:0] cnt0, cnt1;
  logic [4:0]  cnt2;
  logic [2:0]  cnt3;
  logic        pend [4];
  logic        probe0 = 1'b0;

  typedef struct { int dut; logic [31:0] exp; string name; } exp_t;
  exp_t sb [$];
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  svc_rv_imem_resp #(.AW(10), .LATENCY(0)) u0 (
    .clk(clk), .rst_n(rst_n), .imem_ren(ren[0]), .imem_raddr(raddr[0]), .imem_rdata(rdata[0]),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .load_ready(rdy[0]), .load_busy(busy[0]), .load_done(done[0]), .load_count(cnt0),
    .err_overflow(eov[0]), .err_misaligned(emis[0]));
  svc_rv_imem_resp #(.AW(10), .LATENCY(1)) u1 (
    .clk(clk), .rst_n(rst_n), .imem_ren(ren[1]), .imem_raddr(raddr[1]), .imem_rdata(rdata[1]),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .load_ready(rdy[1]), .load_busy(busy[1]), .load_done(done[1]), .load_count(cnt1),
    .err_overflow(eov[1]), .err_misaligned(emis[1]));
  svc_rv_imem_resp #(.AW(4), .LATENCY(1), .BASE(32'h0000_1000)) u2 (
    .clk(clk), .rst_n(rst_n), .imem_ren(ren[2]), .imem_raddr(raddr[2]), .imem_rdata(rdata[2]),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .load_ready(rdy[2]), .load_busy(busy[2]), .load_done(done[2]), .load_count(cnt2),
    .err_overflow(eov[2]), .err_misaligned(emis[2]));
  svc_rv_imem_resp #(.AW(2), .LATENCY(1)) u3 (
    .clk(clk), .rst_n(rst_n), .imem_ren(ren[3]), .imem_raddr(raddr[3]), .imem_rdata(rdata[3]),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .load_ready(rdy[3]), .load_busy(busy[3]), .load_done(done[3]), .load_count(cnt3),
    .err_overflow(eov[3]), .err_misaligned(emis[3]));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic pop_cmp(input int d, input logic [31:0] act);
    exp_t e;
    if (sb.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL unexpected_resp_u%0d: got %h expected no response", d, act);
    end else begin
      e = sb.pop_front();
      check($sformatf("%s_dut", e.name), d, e.dut);
      check(e.name, act, e.exp);
    end
  endtask

  // Monitor: a registered instance presents data the cycle after ren was sampled high;
  // the combinational instance presents data whenever the bench probes it.
  always @(posedge clk) for (int d = 0; d < 4; d++) pend[d] <= ren[d];

  always @(negedge clk) begin
    if (probe0) pop_cmp(0, rdata[0]);
    for (int d = 1; d < 4; d++) if (pend[d]) pop_cmp(d, rdata[d]);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic fetch(input int d, input logic [31:0] a, input logic [31:0] exp, input string nm);
    ren[d] = 1'b1; raddr[d] = a;
    sb.push_back('{d, exp, nm});
    step();
    ren[d] = 1'b0;
  endtask

  task automatic probe_comb(input logic [31:0] a, input logic [31:0] exp, input string nm);
    raddr[0] = a; probe0 = 1'b1;
    sb.push_back('{0, exp, nm});
    step();
    probe0 = 1'b0;
  endtask

  task automatic start_load();
    load_start = 1'b1; step(); load_start = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input logic last);
    load_valid = 1'b1; load_data = d; load_last = last;
    step();
    load_valid = 1'b0; load_last = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 4; d++) begin ren[d] = 1'b0; raddr[d] = '0; end
    #12;
    check("rst_rdata_u1", rdata[1], NOP);
    check("rst_rdata_u2", rdata[2], NOP);
    check("rst_rdata_u3", rdata[3], NOP);
    check("rst_count", cnt1, 0);
    check("rst_done", done[1], 0);
    check("rst_busy", busy[1], 0);
    check("rst_ready", rdy[1], 0);
    check("rst_ovf", eov[1], 0);
    check("rst_mis", emis[1], 0);
    step(); rst_n = 1'b1; step();

    // Overflow: five words into the 4-word instance; fetch during load returns NOP.
    start_load();
    fetch(1, 32'h0, NOP, "fetch_in_load");
    check("busy_in_load", busy[1], 1);
    send(32'h1111_1111, 0); send(32'h2222_2222, 0); send(32'h3333_3333, 0);
    send(32'h4444_4444, 0); send(32'h5555_5555, 1);
    @(negedge clk);
    check("ovf_flag", eov[3], 1);
    check("ovf_count", cnt3, 4);
    check("ovf_done", done[3], 1);
    check("big_count5", cnt1, 5);
    check("big_no_ovf", eov[1], 0);
    step();
    fetch(3, 32'h0, 32'h1111_1111, "ovf_m0");
    fetch(3, 32'h4, 32'h2222_2222, "ovf_m1");
    fetch(3, 32'h8, 32'h3333_3333, "ovf_m2");
    fetch(3, 32'hC, 32'h4444_4444, "ovf_m3");
    fetch(3, 32'h10, NOP, "aw2_oor");

    // Restart mid-load with a colliding handshake, then the real program.
    start_load();
    send(32'hBAD0_0001, 0); send(32'hBAD0_0002, 0);
    load_start = 1'b1; load_valid = 1'b1; load_data = 32'hDEAD_BEEF;
    step();
    load_start = 1'b0; load_valid = 1'b0;
    @(negedge clk);
    check("restart_count", cnt1, 0);
    check("restart_busy", busy[1], 1);
    check("ovf_cleared", eov[3], 0);
    step();
    send(P0, 0); send(P1, 0); send(P2, 0);
    load_valid = 1'b1; load_data = P3; load_last = 1'b1;
    ren[1] = 1'b1; raddr[1] = 32'h0;
    sb.push_back('{1, NOP, "exit_edge"});
    step();
    load_valid = 1'b0; load_last = 1'b0; ren[1] = 1'b0;
    @(negedge clk);
    check("load_count4", cnt1, 4);
    check("load_done", done[1], 1);
    check("load_idle", busy[1], 0);
    check("aw2_count4", cnt3, 4);
    check("aw2_no_ovf", eov[3], 0);
    step();

    // Registered fetch, then hold across a stall while the address moves.
    fetch(1, 32'h8, P2, "fetch_8");
    fetch(1, 32'h4, P1, "fetch_4");
    raddr[1] = 32'hC;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("hold_%0d", i), rdata[1], P1);
    end
    step();
    probe_comb(32'h4, P1, "comb_4");
    probe_comb(32'hC, P3, "comb_c");

    // Misaligned fetch returns the truncated word and latches the flag.
    check("mis_clear", emis[1], 0);
    fetch(1, 32'h6, P1, "fetch_mis");
    @(negedge clk);
    check("mis_set", emis[1], 1);
    step();

    // Range checks against BASE=0x1000, AW=4.
    fetch(2, 32'h0000_0FFC, NOP, "below_base");
    fetch(2, 32'h0000_1040, NOP, "past_end");
    fetch(2, 32'h0000_1000, P0, "base_m0");
    fetch(2, 32'h0000_100C, P3, "base_m3");

    // Async reset after two of four words.
    start_load();
    send(32'hAAAA_0001, 0); send(32'hAAAA_0002, 0);
    @(negedge clk);
    check("pre_rst_count", cnt1, 2);
    check("pre_rst_busy", busy[1], 1);
    check("pre_rst_rdata", rdata[1], P1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy[1], 0);
    check("arst_count", cnt1, 0);
    check("arst_done", done[1], 0);
    check("arst_rdata", rdata[1], NOP);
    step(); rst_n = 1'b1; step();
    fetch(1, 32'h0, 32'hAAAA_0001, "post_rst_m0");
    fetch(1, 32'h4, 32'hAAAA_0002, "post_rst_m1");
    fetch(1, 32'h8, P2, "post_rst_m2");

    repeat (3) step();
    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
